// File: rtl/adc_sample_ctrl.sv
// ADC run controller: conversion clock divider, warm-up discard, burst capture
// into a single-entry valid/ready buffer, out-of-range count and overrun flag.
module adc_sample_ctrl #(
    parameter int DIV_W       = 20,
    parameter int BURST_W     = 16,
    parameter int WARMUP_SMPS = 4
) (
    input  logic               sys_clk_i,
    input  logic               rst_i,
    input  logic [DIV_W-1:0]   cfg_div_i,
    input  logic [BURST_W-1:0] cfg_burst_len_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [7:0]         adc_data_i,
    input  logic               adc_otr_i,
    output logic               adc_clk_o,
    output logic [7:0]         smp_data_o,
    output logic               smp_valid_o,
    input  logic               smp_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [15:0]        otr_cnt_o,
    output logic               overrun_o
);

    // state  | meaning
    // IDLE   | no run; divider and adc_clk parked at 0
    // WARMUP | strobing, samples discarded to flush the ADC pipeline
    // RUN    | strobing, samples captured into the buffer
    // DRAIN  | divider stopped, waiting for the consumer to empty the buffer
    typedef enum logic [1:0] {IDLE, WARMUP, RUN, DRAIN} state_t;

    localparam int WARM_W = $clog2(WARMUP_SMPS + 1);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [WARM_W-1:0]  warm_q, warm_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic [15:0]        otr_q, otr_d;
    logic               ovr_q, ovr_d;
    logic               done_q, done_d;
    logic               clk_q, clk_d;
    logic               active_q, active_d, strobe;

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            burst_q <= '0;
            warm_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            otr_q   <= '0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            warm_q  <= warm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            otr_q   <= otr_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
            clk_q   <= clk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        len_d    = len_q;
        burst_d  = burst_q;
        warm_d   = warm_q;
        data_d   = data_q;
        valid_d  = valid_q;
        otr_d    = otr_q;
        ovr_d    = ovr_q;
        done_d   = 1'b0;
        cnt_d    = '0;
        clk_d    = 1'b0;
        active_q = (state_q == WARMUP) || (state_q == RUN);
        strobe   = active_q && (cnt_q == div_q);

        if (valid_q && smp_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_d = WARMUP;
                    div_d   = (cfg_div_i < DIV_W'(3)) ? DIV_W'(3) : cfg_div_i;
                    len_d   = cfg_burst_len_i;
                    burst_d = '0;
                    warm_d  = '0;
                    otr_d   = '0;
                    ovr_d   = 1'b0;
                end
            end
            WARMUP: begin
                if (stop_i) begin
                    state_d = DRAIN;
                end else if (strobe) begin
                    warm_d = warm_q + WARM_W'(1);
                    if (warm_q == WARM_W'(WARMUP_SMPS - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = DRAIN;
                end else if (strobe) begin
                    burst_d = burst_q + BURST_W'(1);
                    if (adc_otr_i && (otr_q != 16'hFFFF)) begin
                        otr_d = otr_q + 16'd1;
                    end
                    // a sample may replace one being consumed this very cycle
                    if (!valid_q || smp_ready_i) begin
                        data_d  = adc_data_i;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                    if ((len_q != '0) && (burst_d == len_q)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!valid_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // keyed on the next state so adc_clk and cnt are already parked on DRAIN entry
        active_d = (state_d == WARMUP) || (state_d == RUN);
        if (active_d) begin
            if (active_q && (cnt_q != div_q)) begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            if (strobe) begin
                clk_d = 1'b1;
            end else if (cnt_q == (div_q >> 1)) begin
                clk_d = 1'b0;
            end else begin
                clk_d = clk_q;
            end
        end
    end

    assign adc_clk_o   = clk_q;
    assign smp_data_o  = data_q;
    assign smp_valid_o = valid_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign otr_cnt_o   = otr_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl: a cycle-count reference model checked every
// cycle, plus hand-computed expectations on the test-plan scenarios.
module tb_adc_sample_ctrl;

    localparam int WARMUP = 4;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] cfg_div = '0;
    logic [15:0] cfg_burst_len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  adc_data = '0;
    logic        adc_otr = 1'b0;
    logic        smp_ready = 1'b1;
    logic        adc_clk, smp_valid, busy, done, overrun;
    logic [7:0]  smp_data;
    logic [15:0] otr_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    adc_sample_ctrl #(.DIV_W(20), .BURST_W(16), .WARMUP_SMPS(WARMUP)) dut (
        .sys_clk_i(sys_clk), .rst_i(rst), .cfg_div_i(cfg_div),
        .cfg_burst_len_i(cfg_burst_len), .start_i(start), .stop_i(stop),
        .adc_data_i(adc_data), .adc_otr_i(adc_otr), .adc_clk_o(adc_clk),
        .smp_data_o(smp_data), .smp_valid_o(smp_valid), .smp_ready_i(smp_ready),
        .busy_o(busy), .done_o(done), .otr_cnt_o(otr_cnt), .overrun_o(overrun)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;
    always @(negedge sys_clk) adc_data = 8'(cyc);

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a run is described by its first active cycle and divider;
    // strobes and the clock phase follow from cycle arithmetic.
    bit         m_active = 0, m_drain = 0, m_valid = 0, m_ovr = 0, m_done = 0, m_clk = 0;
    logic [7:0] m_data = '0;
    int         m_otr = 0, m_t0 = 0, m_div = 3, m_len = 0, m_nstrb = 0;

    always @(posedge sys_clk or posedge rst) begin
        int  rel, ph;
        bit  strobe, was_active, load, hs;
        if (rst) begin
            m_active = 0; m_drain = 0; m_valid = 0; m_ovr = 0; m_done = 0; m_clk = 0;
            m_data = '0; m_otr = 0;
        end else begin
            was_active = m_active;
            rel    = cyc - m_t0;
            ph     = (rel >= 0) ? rel % (m_div + 1) : 0;
            strobe = m_active && (ph == m_div);
            hs     = m_valid && smp_ready;
            load   = 0;
            m_done = 0;
            if (!m_active && !m_drain) begin
                if (start && !stop) begin
                    m_active = 1; m_t0 = cyc + 1;
                    m_div = (cfg_div < 3) ? 3 : int'(cfg_div);
                    m_len = int'(cfg_burst_len); m_nstrb = 0; m_otr = 0; m_ovr = 0;
                end
            end else if (m_active) begin
                if (stop) begin
                    m_active = 0; m_drain = 1;
                end else if (strobe) begin
                    if (m_nstrb >= WARMUP) begin
                        if (adc_otr && m_otr < 16'hFFFF) m_otr++;
                        if (m_valid && !smp_ready) m_ovr = 1;
                        else load = 1;
                        if (m_len != 0 && (m_nstrb - WARMUP + 1) == m_len) begin
                            m_active = 0; m_drain = 1;
                        end
                    end
                    m_nstrb++;
                end
            end else if (!m_valid) begin
                m_drain = 0; m_done = 1;
            end
            if (load) begin
                m_valid = 1; m_data = adc_data;
            end else if (hs) begin
                m_valid = 0;
            end
            if (m_active && was_active)
                m_clk = (rel >= m_div) && (ph == m_div || ph < (m_div / 2));
            else
                m_clk = 0;
        end
    end

    always @(negedge sys_clk) begin
        if (!rst) begin
            chk("cmp_adc_clk", adc_clk, m_clk);
            chk("cmp_smp_valid", smp_valid, m_valid);
            chk("cmp_smp_data", smp_data, m_data);
            chk("cmp_busy", busy, m_active || m_drain);
            chk("cmp_done", done, m_done);
            chk("cmp_otr_cnt", otr_cnt, m_otr);
            chk("cmp_overrun", overrun, m_ovr);
        end
    end

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic launch(input int div, input int len, output int t);
        cfg_div = 20'(div);
        cfg_burst_len = 16'(len);
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic measure(output int period, output int high);
        int r1, f1, r2;
        logic prev;
        r1 = -1; f1 = -1; r2 = -1;
        prev = adc_clk;
        for (int i = 0; i < 60 && r2 < 0; i++) begin
            tick();
            if (!prev && adc_clk) begin
                if (r1 < 0) r1 = cyc;
                else if (f1 >= 0) r2 = cyc;
            end
            if (prev && !adc_clk && r1 >= 0 && f1 < 0) f1 = cyc;
            prev = adc_clk;
        end
        period = r2 - r1;
        high = f1 - r1;
    endtask

    initial begin
        int t, td, ndone, per, hi;
        logic [7:0] exp_d;

        repeat (2) tick();
        chk("rst_adc_clk", adc_clk, 0);
        chk("rst_smp_valid", smp_valid, 0);
        chk("rst_smp_data", smp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_otr_cnt", otr_cnt, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // start and stop together in IDLE: stop wins; lone stop is ignored
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("idle_start_stop_busy", busy, 0);
        pulse_stop();
        chk("idle_stop_busy", busy, 0);

        // fixed burst of 8, consumer always ready
        smp_ready = 1'b1;
        launch(3, 8, t);
        chk("t1_busy_after_start", busy, 1);
        ndone = 0; td = -1;
        for (int i = 0; i < 60; i++) begin
            if (cyc == t + 21) begin
                exp_d = 8'(t + 20);
                chk("t1_first_valid", smp_valid, 1);
                chk("t1_first_data", smp_data, exp_d);
            end
            if (cyc == t + 49) begin
                exp_d = 8'(t + 48);
                chk("t1_last_data", smp_data, exp_d);
            end
            if (done) begin ndone++; td = cyc; end
            tick();
        end
        chk("t1_done_count", ndone, 1);
        chk("t1_done_cycle", td, t + 51);
        chk("t1_busy_end", busy, 0);
        chk("t1_adc_clk_end", adc_clk, 0);

        // adc_clk waveform, then clamp of a too-small divider
        launch(9, 0, t);
        repeat (30) tick();
        measure(per, hi);
        chk("clk_div9_period", per, 10);
        chk("clk_div9_high", hi, 5);
        pulse_stop();
        wait_done(100, td);
        launch(1, 0, t);
        repeat (20) tick();
        measure(per, hi);
        chk("clk_div1_period", per, 4);
        chk("clk_div1_high", hi, 2);
        pulse_stop();
        wait_done(100, td);

        // stalled consumer: hold, overrun, drops still counted, DRAIN waits
        launch(3, 8, t);
        td = -1;
        for (int i = 0; i < 80; i++) begin
            int rel;
            rel = cyc - t;
            smp_ready = !((rel >= 18 && rel < 30) || (rel >= 46 && rel < 60));
            exp_d = 8'(t + 20);
            if (rel == 25) begin
                chk("t3_held_valid", smp_valid, 1);
                chk("t3_held_data", smp_data, exp_d);
            end
            if (rel == 29) chk("t3_overrun", overrun, 1);
            if (rel == 55) begin
                exp_d = 8'(t + 48);
                chk("t3_drain_busy", busy, 1);
                chk("t3_drain_data", smp_data, exp_d);
            end
            if (done && td < 0) td = cyc;
            tick();
        end
        smp_ready = 1'b1;
        chk("t3_done_cycle", td, t + 62);
        chk("t3_overrun_sticky", overrun, 1);

        // continuous run, stop coinciding with a RUN strobe; start in DRAIN ignored
        launch(3, 0, t);
        for (int i = 0; i < 40 && cyc < t + 32; i++) tick();
        pulse_stop();
        exp_d = 8'(t + 28);
        chk("t4_no_capture_valid", smp_valid, 0);
        chk("t4_no_capture_data", smp_data, exp_d);
        chk("t4_drain_busy", busy, 1);
        chk("t4_drain_adc_clk", adc_clk, 0);
        launch(3, 8, td);
        chk("t4_done", done, 1);
        chk("t4_busy_idle", busy, 0);
        tick();
        chk("t4_start_ignored", busy, 0);

        // otr statistics: warm-up samples never counted
        launch(3, 8, t);
        for (int i = 0; i < 60; i++) begin
            int rel;
            rel = cyc - t;
            adc_otr = (rel <= 17) || rel == 20 || rel == 28 || rel == 40;
            tick();
        end
        adc_otr = 1'b0;
        chk("t5_otr_cnt", otr_cnt, 3);
        launch(3, 8, t);
        chk("t5_otr_cleared", otr_cnt, 0);
        pulse_stop();
        wait_done(100, td);

        // asynchronous reset mid-run
        smp_ready = 1'b0;
        launch(3, 8, t);
        repeat (24) tick();
        chk("t6_pre_reset_valid", smp_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_adc_clk", adc_clk, 0);
        chk("t6_rst_smp_valid", smp_valid, 0);
        chk("t6_rst_smp_data", smp_data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_otr_cnt", otr_cnt, 0);
        chk("t6_rst_overrun", overrun, 0);
        tick();
        rst = 1'b0;
        smp_ready = 1'b1;
        repeat (10) tick();
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_adc_clk", adc_clk, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

Run controller for the ADC front end of the DPSK receiver. It generates the ADC conversion clock from a runtime-programmable divider and sequences each capture run: start, pipeline warm-up discard, fixed-length or continuous burst, stop and drain. Captured samples go to the Costas loop over a valid/ready handshake, together with out-of-range statistics and overrun status. It sits between the ADC pins and the carrier-recovery datapath.

## Interface
- DIV_W, 20, width of divider configuration
- BURST_W, 16, width of burst-length configuration
- WARMUP_SMPS, 4, samples discarded after start (ADC pipeline latency)

- sys_clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cfg_div  in  DIV_W  sample period minus one, in sys_clk cycles; latched on accepted start; values <3 clamp to 3
- cfg_burst_len  in  BURST_W  samples per run, latched on start; 0 = continuous until stop
- start  in  1  single-cycle run request
- stop  in  1  single-cycle abort request
- adc_data  in  8  ADC output word
- adc_otr  in  1  ADC out-of-range flag, aligned with adc_data
- adc_clk  out  1  ADC conversion clock
- smp_data  out  8  captured sample
- smp_valid  out  1  smp_data holds an unconsumed sample
- smp_ready  in  1  consumer accepts the sample
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when a run finishes
- otr_cnt  out  16  number of run samples captured with adc_otr=1; saturates at 0xFFFF
- overrun  out  1  sticky; a sample was dropped because the buffer was full

## Operation
States and transitions:
- IDLE → WARMUP on start with stop=0.
- WARMUP → RUN after WARMUP_SMPS strobes.
- WARMUP or RUN → DRAIN on stop.
- RUN → DRAIN when the burst count reaches cfg_burst_len (nonzero).
- DRAIN → IDLE once the buffer is empty.

Divider and clock:
- div_q is latched on the accepted start.
- cnt runs 0..div_q and wraps to 0; it is held at 0 in IDLE and DRAIN.
- Strobe when cnt==div_q in WARMUP or RUN.
- adc_clk is registered. It goes to 1 the cycle after cnt==div_q and to 0 the cycle after cnt==(div_q>>1).
- adc_clk is held at 0 in IDLE and DRAIN.

Capture:
- On a strobe in WARMUP, adc_data is discarded and the warm-up counter increments.
- On a strobe in RUN, adc_data loads into the single-entry buffer; the burst count increments; otr_cnt increments if adc_otr=1 (saturating).
- Buffer full (smp_valid=1 and smp_ready=0) at a strobe: the sample is dropped, overrun is set, and the burst count and otr_cnt still increment.
- Strobe in the same cycle as a handshake: the new sample loads, smp_valid stays 1, and overrun is not set.

Start and stop rules:
- An accepted start clears otr_cnt, overrun and the burst count.
- start while busy=1 is ignored.
- stop in IDLE is ignored.
- start and stop together in IDLE: stop wins and the block stays IDLE.
- stop in the same cycle as a strobe: that sample is not captured.
- stop in DRAIN has no effect.
- The buffer is never flushed; DRAIN waits for the consumer. If smp_ready stays 0, DRAIN waits indefinitely.

Burst counter:
- Width BURST_W.
- In continuous mode it wraps freely and causes no state change.

## Timing
- Reset (async): state IDLE, cnt=0.
- All outputs are 0 during reset: adc_clk, smp_data, smp_valid, busy, done, otr_cnt, overrun.
- start accepted in cycle t: busy=1 and cnt=0 in cycle t+1.
- Strobes occur at t+1+div_q+k·(div_q+1), for k=0,1,…
- A RUN strobe in cycle c gives smp_valid=1 and the new smp_data in cycle c+1.
- A handshake in cycle h gives smp_valid=0 at h+1, unless a load happens in cycle h.
- The state update to DRAIN takes effect in the cycle after the final strobe.
- DRAIN→IDLE happens in the cycle after smp_valid is 0 (or its last handshake). done=1 and busy=0 in that same cycle.
- smp_data holds its value after a handshake until the next load.

## Test plan
- Fixed burst, consumer always ready: reset, then cfg_div=3, cfg_burst_len=8, smp_ready=1, start at t.
  - Strobes fall at t+4, t+8, …; the first 4 are discarded.
  - smp_valid pulses at t+21, t+25, …, t+49, with the 8 ramp values in order.
  - done pulses exactly once at t+51; afterwards busy=0 and adc_clk=0.
- adc_clk waveform: cfg_div=9 → adc_clk has period 10, with 5 cycles high and 5 low. cfg_div=1 → clamps to period 4.
- Stalled consumer: smp_ready=0 for 3 sample periods in RUN → first sample held, overrun=1, the 2 later samples dropped. Burst still ends after 8 strobes. DRAIN holds until smp_ready=1, then done pulses.
- Continuous run with stop: cfg_burst_len=0, stop issued mid-run, in the same cycle as a strobe → that sample is absent. Entry to DRAIN is the next cycle. A start during DRAIN is ignored.
- otr_cnt: adc_otr=1 on 3 of 8 RUN samples plus on every warm-up sample → otr_cnt=3. A following start clears it to 0.
- Mid-run reset: assert rst mid-run → all outputs 0 immediately (async). After release, the block stays IDLE until a new start.
